// File: rtl/pulse_stretch_if.sv
// Trigger/level bundle for pulse_stretch.
// The master drives trig/len; the stretcher reports level and queue state.
interface pulse_stretch_if #(
   parameter int HOLD_W = 16,
   parameter int PEND_W = 4
);
   logic              trig;
   logic [HOLD_W-1:0] len;
   logic              level_out;
   logic              busy;
   logic [PEND_W-1:0] pend_cnt;
   logic              drop;

   modport master (
      output trig, len,
      input  level_out, busy, pend_cnt, drop
   );

   modport slave (
      input  trig, len,
      output level_out, busy, pend_cnt, drop
   );
endinterface

// File: rtl/pulse_stretch.sv
// Pulse stretcher: single-cycle triggers become levels of len cycles,
// separated by GAP_CYC low cycles. Define PULSE_STRETCH_RETRIG_EN for
// retrigger mode (trig extends/restarts the level, no queue).
module pulse_stretch #(
   parameter int HOLD_W  = 16,
   parameter int GAP_CYC = 2,
   parameter int PEND_W  = 4
) (
   input  logic            clk,
   input  logic            rst,
   pulse_stretch_if.slave  ps
);

   localparam int GW =
      (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   localparam logic [GW-1:0]     GAP_LD = GW'(GAP_CYC);
   localparam logic [GW-1:0]     GAP_1  = GW'(1);
   localparam logic [HOLD_W-1:0] HOLD_1 = HOLD_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      GAP
   } state_t;

   state_t            state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [PEND_W-1:0] pend_q, pend_d;
   logic              drop_q, drop_d;
   logic              level_q;
   logic              busy_q;

   logic [HOLD_W-1:0] len_eff;
   logic              hold_last;
   logic              gap_last;

   // A zero length still yields one visible cycle.
   assign len_eff   = (ps.len == '0) ? HOLD_1 : ps.len;
   assign hold_last = (hold_q == HOLD_1);
   assign gap_last  = (gap_q == GAP_1);

`ifdef PULSE_STRETCH_RETRIG_EN

   // Retrigger mode: trig reloads or restarts the level.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      pend_d  = '0;
      drop_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ps.trig) begin
               state_d = HOLD;
               hold_d  = len_eff;
            end
         end
         HOLD: begin
            if (ps.trig) begin
               hold_d = len_eff;
            end else if (!hold_last) begin
               hold_d = hold_q - HOLD_1;
            end else if (GAP_CYC > 0) begin
               state_d = GAP;
               gap_d   = GAP_LD;
            end else begin
               state_d = IDLE;
            end
         end
         GAP: begin
            if (ps.trig) begin
               state_d = HOLD;
               hold_d  = len_eff;
            end else if (!gap_last) begin
               gap_d = gap_q - GAP_1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`else

   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [PEND_W-1:0] PEND_1   = PEND_W'(1);

   logic enq;
   logic decide;

   // Queued mode: busy-time triggers are counted and replayed.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      pend_d  = pend_q;
      drop_d  = 1'b0;
      enq     = 1'b0;
      decide  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ps.trig) begin
               state_d = HOLD;
               hold_d  = len_eff;
            end
         end
         HOLD: begin
            if (!hold_last) begin
               hold_d = hold_q - HOLD_1;
               enq    = ps.trig;
            end else if (GAP_CYC > 0) begin
               state_d = GAP;
               gap_d   = GAP_LD;
               enq     = ps.trig;
            end else begin
               decide = 1'b1;
            end
         end
         GAP: begin
            if (!gap_last) begin
               gap_d = gap_q - GAP_1;
               enq   = ps.trig;
            end else begin
               decide = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A trig on the deciding edge is serviced at once,
      // so it cancels against the dequeue.
      if (decide) begin
         if (pend_q != '0 || ps.trig) begin
            state_d = HOLD;
            hold_d  = len_eff;
            if (!ps.trig) begin
               pend_d = pend_q - PEND_1;
            end
         end else begin
            state_d = IDLE;
         end
      end

      if (enq) begin
         if (pend_q == PEND_MAX) begin
            drop_d = 1'b1;
         end else begin
            pend_d = pend_q + PEND_1;
         end
      end
   end

`endif

   // State and registered outputs; outputs follow next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hold_q  <= '0;
         gap_q   <= '0;
         pend_q  <= '0;
         drop_q  <= 1'b0;
         level_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         level_q <= (state_d == HOLD);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign ps.level_out = level_q;
   assign ps.busy      = busy_q;
   assign ps.pend_cnt  = pend_q;
   assign ps.drop      = drop_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: two instances (gap 2 / queue 15, and
// gap 0 / queue 3) against a time-window reference model.
module tb_pulse_stretch;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pulse_stretch_if #(.HOLD_W(16), .PEND_W(4)) if0 ();
   pulse_stretch_if #(.HOLD_W(8),  .PEND_W(2)) if1 ();

   pulse_stretch #(
      .HOLD_W(16), .GAP_CYC(2), .PEND_W(4)
   ) u0 (
      .clk(clk), .rst(rst), .ps(if0)
   );

   pulse_stretch #(
      .HOLD_W(8), .GAP_CYC(0), .PEND_W(2)
   ) u1 (
      .clk(clk), .rst(rst), .ps(if1)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   int gapc[2] = '{2, 0};
   int pmax[2] = '{15, 3};

   // Per instance: level window [hi_lo, hi_hi], first edge
   // that may start a new level, queued count, drop flag.
   int hi_lo[2];
   int hi_hi[2];
   int free_at[2];
   int pend[2];
   int drp[2];

   task automatic chk(string tag,
                      logic [31:0] obs,
                      logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                  tag, cyc, obs, exp);
      end
   endtask

   task automatic model(int k, bit t, int l, bit r);
      int len_e;
      int w;
      len_e = (l == 0) ? 1 : l;
      drp[k] = 0;
      if (r) begin
         pend[k]    = 0;
         hi_lo[k]   = 0;
         hi_hi[k]   = -10;
         free_at[k] = 0;
         return;
      end
`ifdef PULSE_STRETCH_RETRIG_EN
      if (t) begin
         if (cyc > hi_hi[k] + 1) hi_lo[k] = cyc;
         hi_hi[k]   = cyc + len_e - 1;
         free_at[k] = cyc + len_e + gapc[k];
      end
`else
      if (cyc < free_at[k]) begin
         if (t) begin
            if (pend[k] == pmax[k]) drp[k] = 1;
            else pend[k]++;
         end
      end else begin
         w = pend[k] + (t ? 1 : 0);
         if (w > 0) begin
            hi_lo[k]   = cyc;
            hi_hi[k]   = cyc + len_e - 1;
            free_at[k] = cyc + len_e + gapc[k];
            pend[k]    = w - 1;
         end
      end
`endif
   endtask

   task automatic step(bit t, int l, bit r);
      bit lv;
      @(negedge clk);
      rst      = r;
      if0.trig = t;
      if0.len  = 16'(l);
      if1.trig = t;
      if1.len  = 8'(l);
      @(posedge clk);
      cyc++;
      model(0, t, l, r);
      model(1, t, l, r);
      #1;
      lv = (cyc >= hi_lo[0]) && (cyc <= hi_hi[0]);
      chk("level0", 32'(if0.level_out), 32'(lv));
      chk("busy0", 32'(if0.busy),
          32'(cyc < free_at[0]));
      chk("pend0", 32'(if0.pend_cnt), pend[0]);
      chk("drop0", 32'(if0.drop), drp[0]);
      lv = (cyc >= hi_lo[1]) && (cyc <= hi_hi[1]);
      chk("level1", 32'(if1.level_out), 32'(lv));
      chk("busy1", 32'(if1.busy),
          32'(cyc < free_at[1]));
      chk("pend1", 32'(if1.pend_cnt), pend[1]);
      chk("drop1", 32'(if1.drop), drp[1]);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
   endtask

   initial begin
      int pct;
      bit t;
      bit r;
      rst      = 1'b1;
      if0.trig = 1'b0;
      if0.len  = '0;
      if1.trig = 1'b0;
      if1.len  = '0;

      // reset, then quiet
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      idle(20);

      // single level, len 5
      step(1'b1, 5, 1'b0);
      idle(12);

      // triggers queued behind a short level
      step(1'b1, 3, 1'b0);
      step(1'b0, 3, 1'b0);
      step(1'b1, 3, 1'b0);
      step(1'b1, 3, 1'b0);
      idle(20);

      // burst while holding: saturates the small queue
      step(1'b1, 10, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 10, 1'b0);
      idle(90);

      // zero length
      step(1'b1, 0, 1'b0);
      idle(5);

      // reset in the middle of a queued 8-cycle level
      step(1'b1, 8, 1'b0);
      step(1'b1, 8, 1'b0);
      step(1'b0, 8, 1'b0);
      step(1'b0, 8, 1'b0);
      step(1'b0, 0, 1'b1);
      idle(6);

      // retrigger-style spacing
      step(1'b1, 4, 1'b0);
      step(1'b0, 4, 1'b0);
      step(1'b1, 4, 1'b0);
      idle(12);

      // random traffic, varying density
      for (int i = 0; i < 4000; i++) begin
         unique case ((i / 400) % 3)
            0:       pct = 5;
            1:       pct = 30;
            default: pct = 70;
         endcase
         t = ($urandom_range(0, 99) < pct);
         r = ($urandom_range(0, 299) == 0);
         step(t, int'($urandom_range(0, 7)), r);
      end
      idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
